// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline.
// It adds a multi-cycle load freeze (LOAD_LAT) and saturating stall/flush counters.
module hazard_forward_unit #(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_forwarding_i,
  input  logic [RA_W-1:0]   id_rs_i,
  input  logic [RA_W-1:0]   id_rt_i,
  input  logic              id_rs_used_i,
  input  logic              id_rt_used_i,
  input  logic [RA_W-1:0]   ex_rs_i,
  input  logic [RA_W-1:0]   ex_rt_i,
  input  logic [DATA_W-1:0] ex_rs_val_i,
  input  logic [DATA_W-1:0] ex_rt_val_i,
  input  logic [RA_W-1:0]   ex_rd_i,
  input  logic              ex_regwrite_i,
  input  logic              ex_memread_i,
  input  logic              branch_taken_i,
  input  logic [RA_W-1:0]   mem_rd_i,
  input  logic              mem_regwrite_i,
  input  logic              mem_memread_i,
  input  logic [DATA_W-1:0] mem_alu_result_i,
  input  logic [RA_W-1:0]   wb_rd_i,
  input  logic              wb_regwrite_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              cnt_clr_i,
  output logic              pc_write_o,
  output logic              if_id_we_o,
  output logic              if_id_flush_o,
  output logic              id_ex_bubble_o,
  output logic              mem_freeze_o,
  output logic              mem_wb_bubble_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              state_o
);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [3:0] LAT_INIT = (LOAD_LAT > 0) ? 4'(LOAD_LAT - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             freeze_raw, freeze;
  logic             load_use, raw_stall, data_stall, stall_evt, flush_evt;

  // Register 0 is hardwired zero, so it never produces a hazard or a bypass.
  function automatic logic hit(input logic we, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] src, input logic used);
    return we && (rd != '0) && (rd == src) && used;
  endfunction

  logic mem_fwd_ok;
  assign mem_fwd_ok = mem_regwrite_i && !mem_memread_i;

  always_comb begin
    fwd_a_sel_o = 2'd0;
    fwd_b_sel_o = 2'd0;
    if (enable_forwarding_i) begin
      if (hit(mem_fwd_ok, mem_rd_i, ex_rs_i, 1'b1))         fwd_a_sel_o = 2'd2;
      else if (hit(wb_regwrite_i, wb_rd_i, ex_rs_i, 1'b1))  fwd_a_sel_o = 2'd1;
      if (hit(mem_fwd_ok, mem_rd_i, ex_rt_i, 1'b1))         fwd_b_sel_o = 2'd2;
      else if (hit(wb_regwrite_i, wb_rd_i, ex_rt_i, 1'b1))  fwd_b_sel_o = 2'd1;
    end
  end

  always_comb begin
    case (fwd_a_sel_o)
      2'd2:    op_a_o = mem_alu_result_i;
      2'd1:    op_a_o = wb_data_i;
      default: op_a_o = ex_rs_val_i;
    endcase
    case (fwd_b_sel_o)
      2'd2:    op_b_o = mem_alu_result_i;
      2'd1:    op_b_o = wb_data_i;
      default: op_b_o = ex_rt_val_i;
    endcase
  end

  // Without forwarding the regfile has no bypass, so any in-flight writer stalls ID.
  always_comb begin
    load_use  = enable_forwarding_i && ex_memread_i &&
                (hit(ex_regwrite_i, ex_rd_i, id_rs_i, id_rs_used_i) ||
                 hit(ex_regwrite_i, ex_rd_i, id_rt_i, id_rt_used_i));
    raw_stall = !enable_forwarding_i &&
                (hit(ex_regwrite_i,  ex_rd_i,  id_rs_i, id_rs_used_i) ||
                 hit(ex_regwrite_i,  ex_rd_i,  id_rt_i, id_rt_used_i) ||
                 hit(mem_regwrite_i, mem_rd_i, id_rs_i, id_rs_used_i) ||
                 hit(mem_regwrite_i, mem_rd_i, id_rt_i, id_rt_used_i) ||
                 hit(wb_regwrite_i,  wb_rd_i,  id_rs_i, id_rs_used_i) ||
                 hit(wb_regwrite_i,  wb_rd_i,  id_rt_i, id_rt_used_i));
    data_stall = load_use || raw_stall;
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    freeze_raw = 1'b0;
    if (LOAD_LAT > 0) begin
      case (state_q)
        ST_RUN: if (mem_memread_i) begin
          freeze_raw = 1'b1;
          state_d    = ST_WAIT;
          lat_d      = LAT_INIT;
        end
        ST_WAIT: if (lat_q != 4'd0) begin
          freeze_raw = 1'b1;
          lat_d      = lat_q - 4'd1;
        end else begin
          state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Reset drops the freeze at once even if a load is still sitting in MEM.
  assign freeze = freeze_raw && !rst;

  always_comb begin
    pc_write_o      = 1'b1;
    if_id_we_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    mem_freeze_o    = 1'b0;
    mem_wb_bubble_o = 1'b0;
    if (freeze) begin
      mem_freeze_o    = 1'b1;
      mem_wb_bubble_o = 1'b1;
      pc_write_o      = 1'b0;
      if_id_we_o      = 1'b0;
    end else if (branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (data_stall) begin
      pc_write_o     = 1'b0;
      if_id_we_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end
  end

  assign stall_evt = freeze || (data_stall && !branch_taken_i);
  assign flush_evt = !freeze && branch_taken_i;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr_i) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      lat_q   <= 4'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
  assign state_o     = state_q;

endmodule
